// File: rtl/regfile_writeback.sv
// Writeback arbiter for the register-file write port. ALU results win by default.
// Load results are queued in a FIFO, and a starvation guard forces periodic drains.
module regfile_writeback #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [4:0]                 lsu_rd,
    input  logic [31:0]                lsu_data,
    output logic                       RegWrite,
    output logic [4:0]                 write_register,
    output logic [31:0]                write_data,
    output logic [$clog2(DEPTH+1)-1:0] pending
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DepthCnt  = CW'(DEPTH);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          we_q, we_d;
    logic [4:0]    wreg_q, wreg_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          alu_fire, push, pop;

    always_comb begin
        alu_ready = (starve_q < StarveMax);
        lsu_ready = (cnt_q < DepthCnt);
        alu_fire  = alu_valid && alu_ready;
        push      = lsu_valid && lsu_ready;
        pop       = !alu_fire && (cnt_q != '0);

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CW'(1);
        end

        // Count only ALU wins that kept a non-empty FIFO waiting.
        starve_d = starve_q;
        if (pop || cnt_q == '0) begin
            starve_d = '0;
        end else if (alu_fire && starve_q < StarveMax) begin
            starve_d = starve_q + SW'(1);
        end

        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (alu_fire) begin
            we_d    = (alu_rd != 5'd0);
            wreg_d  = alu_rd;
            wdata_d = alu_data;
        end else if (pop) begin
            we_d    = (rd_mem[rd_ptr_q] != 5'd0);
            wreg_d  = rd_mem[rd_ptr_q];
            wdata_d = data_mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end

    // Storage needs no reset; the pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_q]   <= lsu_rd;
            data_mem[wr_ptr_q] <= lsu_data;
        end
    end

    assign RegWrite       = we_q;
    assign write_register = wreg_q;
    assign write_data     = wdata_q;
    assign pending        = cnt_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset, ALU path, r0, FIFO order, starvation, push/pop.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        RegWrite;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic [2:0]  pending;

    int total = 0;
    int bad   = 0;

    regfile_writeback #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .lsu_valid      (lsu_valid),
        .lsu_ready      (lsu_ready),
        .lsu_rd         (lsu_rd),
        .lsu_data       (lsu_data),
        .RegWrite       (RegWrite),
        .write_register (write_register),
        .write_data     (write_data),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] rd,
                          input logic [31:0] d, input logic [2:0] pend);
        chk({tag, "_we"}, 32'(RegWrite), 32'(we));
        if (we) begin
            chk({tag, "_rd"}, 32'(write_register), 32'(rd));
            chk({tag, "_data"}, write_data, d);
        end
        chk({tag, "_pend"}, 32'(pending), 32'(pend));
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v; alu_rd = rd; alu_data = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lsu_valid = v; lsu_rd = rd; lsu_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        alu(1'b0, 5'd0, 32'h0);
        lsu(1'b0, 5'd0, 32'h0);
        #2;
        chk("rst_we", 32'(RegWrite), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        // ALU only
        alu(1'b1, 5'd5, 32'hDEADBEEF);
        step();
        chk_wr("alu", 1'b1, 5'd5, 32'hDEADBEEF, 3'd0);
        alu(1'b0, 5'd0, 32'h0);
        step();
        chk("alu_idle_we", 32'(RegWrite), 32'd0);
        chk("alu_hold_rd", 32'(write_register), 32'd5);

        // r0 suppression
        alu(1'b1, 5'd0, 32'h1234);
        step();
        chk_wr("r0_alu", 1'b0, 5'd0, 32'h0, 3'd0);
        chk("r0_alu_data", write_data, 32'h1234);
        alu(1'b0, 5'd0, 32'h0);
        lsu(1'b1, 5'd0, 32'h55);
        step();
        chk_wr("r0_push", 1'b0, 5'd0, 32'h0, 3'd1);
        lsu(1'b0, 5'd0, 32'h0);
        step();
        chk_wr("r0_pop", 1'b0, 5'd0, 32'h0, 3'd0);
        chk("r0_pop_data", write_data, 32'h55);

        // FIFO fill while ALU busy; guard trips exactly as the FIFO fills
        for (int i = 1; i <= 4; i++) begin
            alu(1'b1, 5'd20, 32'(100 + i));
            lsu(1'b1, 5'(i), 32'(i * 17));
            step();
            chk_wr("fill_alu", 1'b1, 5'd20, 32'(100 + i), 3'(i));
        end
        chk("full_lsu_ready", 32'(lsu_ready), 32'd0);
        chk("full_alu_ready", 32'(alu_ready), 32'd0);
        alu(1'b0, 5'd0, 32'h0);
        lsu(1'b0, 5'd0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_wr("drain", 1'b1, 5'(i), 32'(i * 17), 3'(4 - i));
        end
        step();
        chk("drain_idle_we", 32'(RegWrite), 32'd0);

        // Starvation
        alu(1'b1, 5'd10, 32'hA0);
        lsu(1'b1, 5'd9, 32'hAA);
        step();
        chk_wr("st_a", 1'b1, 5'd10, 32'hA0, 3'd1);
        lsu(1'b0, 5'd0, 32'h0);
        alu(1'b1, 5'd11, 32'hB0);
        step();
        chk_wr("st_b", 1'b1, 5'd11, 32'hB0, 3'd1);
        chk("st_b_ready", 32'(alu_ready), 32'd1);
        alu(1'b1, 5'd12, 32'hC0);
        step();
        chk_wr("st_c", 1'b1, 5'd12, 32'hC0, 3'd1);
        chk("st_c_ready", 32'(alu_ready), 32'd1);
        alu(1'b1, 5'd13, 32'hD0);
        step();
        chk_wr("st_d", 1'b1, 5'd13, 32'hD0, 3'd1);
        chk("st_d_ready", 32'(alu_ready), 32'd0);
        alu(1'b1, 5'd14, 32'hE0);
        step();
        chk_wr("st_drain", 1'b1, 5'd9, 32'hAA, 3'd0);
        chk("st_e_ready", 32'(alu_ready), 32'd1);
        step();
        chk_wr("st_held", 1'b1, 5'd14, 32'hE0, 3'd0);
        alu(1'b0, 5'd0, 32'h0);
        step();

        // Simultaneous push/pop at pending=2
        for (int i = 0; i < 2; i++) begin
            alu(1'b1, 5'd30, 32'(48 + i));
            lsu(1'b1, 5'(21 + i), 32'(33 + i));
            step();
            chk_wr("pp_fill", 1'b1, 5'd30, 32'(48 + i), 3'(i + 1));
        end
        alu(1'b0, 5'd0, 32'h0);
        for (int i = 2; i < 5; i++) begin
            lsu(1'b1, 5'(21 + i), 32'(33 + i));
            step();
            chk_wr("pp_steady", 1'b1, 5'(21 + i - 2), 32'(33 + i - 2), 3'd2);
        end
        lsu(1'b0, 5'd0, 32'h0);
        step();
        chk_wr("pp_tail1", 1'b1, 5'd24, 32'd36, 3'd1);
        step();
        chk_wr("pp_tail2", 1'b1, 5'd25, 32'd37, 3'd0);
        step();

        // Reset mid-stream with two entries pending
        for (int i = 0; i < 2; i++) begin
            alu(1'b1, 5'd7, 32'(112 + i));
            lsu(1'b1, 5'(1 + i), 32'(80 + i));
            step();
        end
        chk("mid_pend", 32'(pending), 32'd2);
        alu(1'b0, 5'd0, 32'h0);
        lsu(1'b0, 5'd0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(RegWrite), 32'd0);
        chk("mid_rst_pend", 32'(pending), 32'd0);
        chk("mid_rst_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("mid_rst_alu_ready", 32'(alu_ready), 32'd1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_we", 32'(RegWrite), 32'd0);
            chk("post_rst_pend", 32'(pending), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
